cp0_exc_unit: RTL

Parametrised successor to the memory-stage exception decoder. It merges exception prioritisation with the CP0 state it depends on: Status, Cause, EPC, BadVAddr, Count and Compare. It also provides a configurable hardware-interrupt width, a Count/Compare timer interrupt, branch-delay-slot EPC correction and an MTC0/MFC0 access port. It sits at the M stage, drives the pipeline flush and redirect PC, and owns all exception-related architectural state.

---
 rtl/cp0_exc_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/cp0_exc_unit.sv
// M-stage exception prioritisation together with the CP0 state it owns:
// Status, Cause, EPC, BadVAddr, Count/Compare timer and an MTC0/MFC0 port.
module cp0_exc_unit #(
  parameter int          N_HW_INT   = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          TIMER_DIV  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_HW_INT-1:0] hw_int,
  input  logic                valid_m,
  input  logic                stall_m,
  input  logic [31:0]         pc_m,
  input  logic [31:0]         addr_m,
  input  logic                in_ds_m,
  input  logic                adel_if,
  input  logic                adel_ld,
  input  logic                ades,
  input  logic                ri,
  input  logic                syscall,
  input  logic                brk,
  input  logic                ov,
  input  logic                trap,
  input  logic                eret,
  input  logic                mtc0_en,
  input  logic [4:0]          cp0_waddr,
  input  logic [4:0]          cp0_raddr,
  input  logic [31:0]         cp0_wdata,
  output logic [31:0]         cp0_rdata,
  output logic                flush,
  output logic [31:0]         redirect_pc,
  output logic [4:0]          exc_code,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         epc_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam int             DIV_W    = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TIMER_DIV - 1);

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c,
    EXC_TR   = 5'h0d
  } exc_code_e;

  logic [N_HW_INT-1:0] hw_sync;
  logic [N_HW_INT-1:0] hw_ip;
  logic [7:0]          status_im;
  logic                status_exl;
  logic                status_ie;
  logic                cause_bd;
  logic                cause_ti;
  logic [1:0]          cause_sw;
  logic [4:0]          cause_code;
  logic [31:0]         epc;
  logic [31:0]         badvaddr;
  logic [31:0]         count;
  logic [31:0]         compare;
  logic [DIV_W-1:0]    div;

  logic [5:0]       hw_pad;
  logic [7:0]       ip;
  logic             int_pend;
  logic             go;
  logic             exc_taken;
  logic             eret_taken;
  exc_code_e        code;
  logic             mtc0_ok;
  logic             tick;
  logic             count_wr;
  logic             compare_wr;
  logic [31:0]      count_next;
  logic [DIV_W-1:0] div_next;

  // IP[7] is shared between hardware line 5 and the timer interrupt.
  assign hw_pad   = 6'(hw_ip);
  assign ip       = {hw_pad[5] | cause_ti, hw_pad[4:0], cause_sw};
  assign int_pend = status_ie & ~status_exl & (|(status_im & ip));
  assign go       = valid_m & ~stall_m;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    exc_taken  = 1'b0;
    eret_taken = 1'b0;
    code       = EXC_INT;
    if (go) begin
      exc_taken = 1'b1;
      if (int_pend)                code = EXC_INT;
      else if (adel_if || adel_ld) code = EXC_ADEL;
      else if (ri)                 code = EXC_RI;
      else if (syscall)            code = EXC_SYS;
      else if (brk)                code = EXC_BP;
      else if (ades)               code = EXC_ADES;
      else if (ov)                 code = EXC_OV;
      else if (trap)               code = EXC_TR;
      else begin
        exc_taken  = 1'b0;
        eret_taken = eret;
      end
    end
  end

  assign flush       = exc_taken | eret_taken;
  assign redirect_pc = exc_taken ? EXC_VECTOR : (eret_taken ? epc : 32'h0);
  assign exc_code    = exc_taken ? code : 5'h0;

  // A taken exception or eret suppresses any same-cycle CP0 write.
  assign mtc0_ok    = mtc0_en & ~stall_m & ~flush;
  assign count_wr   = mtc0_ok && (cp0_waddr == REG_COUNT);
  assign compare_wr = mtc0_ok && (cp0_waddr == REG_COMPARE);
  assign tick       = (div == DIV_LAST);
  assign count_next = count_wr ? cp0_wdata : (tick ? count + 32'd1 : count);
  assign div_next   = (count_wr || tick) ? '0 : div + 1'b1;

  assign status_o = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
  assign cause_o  = {cause_bd, cause_ti, 14'd0, ip, 1'b0, cause_code, 2'b00};
  assign epc_o    = epc;

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_raddr)
      REG_BADVADDR: cp0_rdata = badvaddr;
      REG_COUNT:    cp0_rdata = count;
      REG_COMPARE:  cp0_rdata = compare;
      REG_STATUS:   cp0_rdata = status_o;
      REG_CAUSE:    cp0_rdata = cause_o;
      REG_EPC:      cp0_rdata = epc;
      default:      cp0_rdata = 32'h0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_sync    <= '0;
      hw_ip      <= '0;
      status_im  <= 8'h0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
      cause_bd   <= 1'b0;
      cause_ti   <= 1'b0;
      cause_sw   <= 2'b00;
      cause_code <= 5'h0;
      epc        <= 32'h0;
      badvaddr   <= 32'h0;
      count      <= 32'h0;
      compare    <= 32'h0;
      div        <= '0;
    end else begin
      hw_sync <= hw_int;
      hw_ip   <= hw_sync;
      count   <= count_next;
      div     <= div_next;

      if (compare_wr) begin
        compare  <= cp0_wdata;
        cause_ti <= 1'b0;
      end else if ((count_next == compare) && (compare != 32'h0)) begin
        cause_ti <= 1'b1;
      end

      if (exc_taken) begin
        cause_code <= code;
        status_exl <= 1'b1;
        // A nested exception keeps the original return point.
        if (!status_exl) begin
          epc      <= in_ds_m ? pc_m - 32'd4 : pc_m;
          cause_bd <= in_ds_m;
        end
        if (code == EXC_ADEL || code == EXC_ADES)
          badvaddr <= adel_if ? pc_m : addr_m;
      end else if (eret_taken) begin
        status_exl <= 1'b0;
      end else if (mtc0_ok) begin
        case (cp0_waddr)
          REG_STATUS: begin
            status_im  <= cp0_wdata[15:8];
            status_exl <= cp0_wdata[1];
            status_ie  <= cp0_wdata[0];
          end
          REG_CAUSE: cause_sw <= cp0_wdata[9:8];
          REG_EPC:   epc      <= cp0_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule
